data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressable, big-endian data memory for the single-cycle CPU datapath.
- Supports word and byte accesses at any byte address, with registered read data.
- Out-of-range accesses are flagged with an error instead of being silently dropped.
- After reset, a clear sequencer zeroes the whole array; requests are held off until it finishes.

---
 rtl/data_memory_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressable big-endian data memory with registered reads, range
// checking and a post-reset clear sequencer that zeroes the array.
module data_memory_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_BYTES = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic                  size,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  err
);

    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned IW  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned EW  = ADDR_WIDTH + 1;

    localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH_BYTES - BPW);
    localparam logic [IW-1:0] PTR_STEP = IW'(BPW);
    localparam logic [EW-1:0] DEPTH_E  = EW'(DEPTH_BYTES);
    localparam logic [EW-1:0] WORD_LEN = EW'(BPW);
    localparam logic [EW-1:0] BYTE_LEN = EW'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]            ram [DEPTH_BYTES];
    logic [IW-1:0]         ptr;
    logic                  clear_en;
    logic                  accept;
    logic                  legal;
    logic [EW-1:0]         acc_len;
    logic [IW-1:0]         idx     [BPW];
    logic [IW-1:0]         clr_idx [BPW];
    logic [DATA_WIDTH-1:0] rd_word;

    // Requests are taken only in IDLE and never in a reset cycle
    assign ready  = (state == IDLE) && !rst;
    assign accept = req && ready;

    // Range check done one bit wider than the address so it cannot wrap
    assign acc_len = size ? WORD_LEN : BYTE_LEN;
    assign legal   = (({1'b0, address} + acc_len) <= DEPTH_E);

    // Byte indices for the access and for the clear sequencer
    always_comb begin
        for (int k = 0; k < BPW; k++) begin
            idx[k]     = IW'(address + ADDR_WIDTH'(k));
            clr_idx[k] = ptr + IW'(k);
        end
    end

    // Big-endian read assembly; byte reads are zero-extended
    always_comb begin
        rd_word = '0;
        if (size) begin
            for (int k = 0; k < BPW; k++) begin
                rd_word[DATA_WIDTH-1-8*k -: 8] = ram[idx[k]];
            end
        end else begin
            rd_word[7:0] = ram[idx[0]];
        end
    end

    // Next-state logic: CLEAR walks the array once, then IDLE forever
    always_comb begin
        next_state = state;
        clear_en   = 1'b0;
        case (state)
            CLEAR: begin
                clear_en = 1'b1;
                if (ptr == LAST_PTR) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Storage array: clear writes zeros, legal writes store big-endian
    always_ff @(posedge clk) begin
        if (clear_en) begin
            for (int k = 0; k < BPW; k++) begin
                ram[clr_idx[k]] <= 8'h00;
            end
        end else if (accept && we && legal) begin
            if (size) begin
                for (int k = 0; k < BPW; k++) begin
                    ram[idx[k]] <= wdata[DATA_WIDTH-1-8*k -: 8];
                end
            end else begin
                ram[idx[0]] <= wdata[7:0];
            end
        end
    end

    // Clear pointer and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (clear_en) begin
                ptr <= ptr + PTR_STEP;
            end
            if (accept) begin
                if (!legal) begin
                    err    <= 1'b1;
                    rvalid <= !we;
                    rdata  <= '0;
                end else if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: byte-array model plus a
// scoreboard queue of expected responses.
module tb_data_memory_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic        size;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        err;

    typedef struct packed {
        logic        rv;
        logic        er;
        logic [15:0] rd;
    } exp_t;

    exp_t       sbq [$];
    logic [7:0] mem [128];
    logic [15:0] m_rdata;
    int n_pass;
    int n_total;

    data_memory_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH_BYTES(128)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .size   (size),
        .address(address),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock of stimulus; expected response is pushed before the edge
    // and popped/compared just after it.
    task automatic step(input string tag, input logic in_clear, input logic r,
                        input logic w, input logic s, input logic [15:0] a,
                        input logic [15:0] d);
        exp_t e;
        exp_t got;
        int   n;
        bit   lgl;
        req = r; we = w; size = s; address = a; wdata = d;
        #1;
        check({tag, ":ready"}, 32'(ready), in_clear ? 32'd0 : 32'd1);
        e = '{rv: 1'b0, er: 1'b0, rd: m_rdata};
        if (r && !in_clear) begin
            n   = s ? 2 : 1;
            lgl = (int'(a) + n) <= 128;
            if (!lgl) begin
                m_rdata = 16'h0000;
                e = '{rv: !w, er: 1'b1, rd: 16'h0000};
            end else if (w) begin
                if (s) begin
                    mem[a]   = d[15:8];
                    mem[a+1] = d[7:0];
                end else begin
                    mem[a] = d[7:0];
                end
            end else begin
                m_rdata = s ? {mem[a], mem[a+1]} : {8'h00, mem[a]};
                e = '{rv: 1'b1, er: 1'b0, rd: m_rdata};
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        got = '{rv: rvalid, er: err, rd: rdata};
        e = sbq.pop_front();
        check({tag, ":rvalid"}, 32'(got.rv), 32'(e.rv));
        check({tag, ":err"},    32'(got.er), 32'(e.er));
        check({tag, ":rdata"},  32'(got.rd), 32'(e.rd));
    endtask

    // Pulse reset for one cycle and model the clear of the array
    task automatic pulse_reset();
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("ready_in_rst", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_rdata = 16'h0000;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_rdata",  32'(rdata),  32'd0);
    endtask

    // Count cycles with ready low after reset; bounded wait
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, ":clear_cycles"}, 32'(cnt), 32'd64);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0;
        address = '0; wdata = '0;
        n_pass = 0; n_total = 0; m_rdata = '0;
        @(posedge clk);
        #1;

        // Reset, clear duration, all-zero word reads
        pulse_reset();
        wait_clear("init");
        for (int i = 0; i < 128; i += 2) step("zero_rd", 1'b0, 1'b1, 1'b0, 1'b1, 16'(i), 16'h0);

        // Word write then word/byte reads
        step("wr1234",  1'b0, 1'b1, 1'b1, 1'b1, 16'd4, 16'h1234);
        step("rdw4",    1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'h0);
        step("rdb4",    1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'h0);
        step("rdb5",    1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 16'h0);
        step("idle1",   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0);

        // Byte write merges; misaligned word read
        step("wrbAB",   1'b0, 1'b1, 1'b1, 1'b0, 16'd5, 16'hFFAB);
        step("rdw4b",   1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'h0);
        step("rdw5",    1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'h0);

        // Range boundaries
        step("wrw127",  1'b0, 1'b1, 1'b1, 1'b1, 16'd127, 16'h5566);
        step("rdw127",  1'b0, 1'b1, 1'b0, 1'b1, 16'd127, 16'h0);
        step("rdb127",  1'b0, 1'b1, 1'b0, 1'b0, 16'd127, 16'h0);
        step("wrw126",  1'b0, 1'b1, 1'b1, 1'b1, 16'd126, 16'hC0DE);
        step("rdw126",  1'b0, 1'b1, 1'b0, 1'b1, 16'd126, 16'h0);
        step("rdb128",  1'b0, 1'b1, 1'b0, 1'b0, 16'd128, 16'h0);
        step("wrbFFFF", 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0077);
        step("rdwFFFF", 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0);
        step("idle2",   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0);

        // Back-to-back write/read, no bubbles
        step("wrBEEF",  1'b0, 1'b1, 1'b1, 1'b1, 16'd10, 16'hBEEF);
        step("rdBEEF",  1'b0, 1'b1, 1'b0, 1'b1, 16'd10, 16'h0);
        step("wr20",    1'b0, 1'b1, 1'b1, 1'b1, 16'd20, 16'hA55A);
        step("rd20",    1'b0, 1'b1, 1'b0, 1'b1, 16'd20, 16'h0);
        step("rdb11",   1'b0, 1'b1, 1'b0, 1'b0, 16'd11, 16'h0);

        // Reset, then reset again at CLEAR cycle 30; requests ignored in CLEAR
        pulse_reset();
        for (int i = 0; i < 30; i++) step("in_clear", 1'b1, 1'b1, 1'b1, 1'b1, 16'd100, 16'h7777);
        pulse_reset();
        wait_clear("restart");
        for (int i = 0; i < 128; i += 2) step("zero_rd2", 1'b0, 1'b1, 1'b0, 1'b1, 16'(i), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
